// File: rtl/aes_sched.sv
`default_nettype none
// ============================================================================
// aes_sched : two-requester round-robin front end and result tagger for a
//             pipelined aes_128 core.                              Rev 1.0
// ============================================================================
module aes_sched #(
  parameter int WIDTH   = 128,
  parameter int LATENCY = 21
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_state,
  input  logic [2*WIDTH-1:0] req_key,
  output logic [WIDTH-1:0]   core_state,
  output logic [WIDTH-1:0]   core_key,
  input  logic [WIDTH-1:0]   core_out,
  output logic               out_valid,
  output logic               out_id,
  output logic [WIDTH-1:0]   out_data,
  output logic [4:0]         inflight,
  output logic [31:0]        done_count
);

  logic               rr_ptr;
  logic               fire;
  logic               fire_id;
  logic [LATENCY-1:0] pipe_vld;
  logic [LATENCY-1:0] pipe_id;
  logic               last_vld;
  logic               last_id;

  // A lone requester always wins; on contention the pointer decides.
  always_comb begin
    req_ready = 2'b00;
    if (en && !rst) begin
      req_ready[0] = req_valid[0] & (~req_valid[1] | ~rr_ptr);
      req_ready[1] = req_valid[1] & (~req_valid[0] |  rr_ptr);
    end
  end

  assign fire    = |(req_valid & req_ready);
  assign fire_id = req_valid[1] & req_ready[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= 1'b0;
      core_state <= '0;
      core_key   <= '0;
      pipe_vld   <= '0;
      pipe_id    <= '0;
      last_vld   <= 1'b0;
      last_id    <= 1'b0;
      inflight   <= 5'd0;
      done_count <= 32'd0;
    end else begin
      if (fire) begin
        rr_ptr     <= ~fire_id;
        core_state <= req_state[(fire_id ? WIDTH : 0) +: WIDTH];
        core_key   <= req_key[(fire_id ? WIDTH : 0) +: WIDTH];
      end
      pipe_vld <= {pipe_vld[LATENCY-2:0], fire};
      pipe_id  <= {pipe_id[LATENCY-2:0], fire_id};
      last_vld <= pipe_vld[LATENCY-1];
      last_id  <= pipe_id[LATENCY-1];

      // Counted window is the LATENCY tag stages; the output register sits after it.
      case ({fire, pipe_vld[LATENCY-1]})
        2'b10:   inflight <= inflight + 5'd1;
        2'b01:   inflight <= inflight - 5'd1;
        default: inflight <= inflight;
      endcase

      if (out_valid) begin
        done_count <= done_count + 32'd1;
      end
    end
  end

  assign out_valid = last_vld & ~rst;
  assign out_id    = last_id & last_vld & ~rst;
  assign out_data  = out_valid ? core_out : '0;

endmodule
`default_nettype wire

// File: tb/tb_aes_sched.sv
`default_nettype none
// tb_aes_sched : directed bench; a behavioural AES-128 core with LATENCY
//                stages sits behind the scheduler as the golden reference.
module tb_aes_sched;
  localparam int WIDTH   = 128;
  localparam int LATENCY = 21;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               en = 1'b1;
  logic [1:0]         req_valid = 2'b00;
  logic [1:0]         req_ready;
  logic [2*WIDTH-1:0] req_state = '0;
  logic [2*WIDTH-1:0] req_key = '0;
  logic [WIDTH-1:0]   core_state;
  logic [WIDTH-1:0]   core_key;
  logic [WIDTH-1:0]   core_out;
  logic               out_valid;
  logic               out_id;
  logic [WIDTH-1:0]   out_data;
  logic [4:0]         inflight;
  logic [31:0]        done_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  aes_sched #(.WIDTH(WIDTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_state(req_state), .req_key(req_key),
    .core_state(core_state), .core_key(core_key), .core_out(core_out),
    .out_valid(out_valid), .out_id(out_id), .out_data(out_data),
    .inflight(inflight), .done_count(done_count)
  );

  // ---------------- AES-128 reference ----------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] r;
    logic [7:0] xb;
    for (int x = 0; x < 256; x++) begin
      xb  = x[7:0];
      inv = 8'h00;
      if (x != 0) begin
        r = 8'h01;
        for (int e = 0; e < 254; e++) r = gmul(r, xb);
        inv = r;
      end
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   k [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      k[i] = key[127-8*i -: 8];
      s[i] = pt[127-8*i -: 8] ^ k[i];
    end
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      a0 = sbox[k[13]] ^ rc;
      a1 = sbox[k[14]];
      a2 = sbox[k[15]];
      a3 = sbox[k[12]];
      k[0] = k[0] ^ a0; k[1] = k[1] ^ a1; k[2] = k[2] ^ a2; k[3] = k[3] ^ a3;
      for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
      rc = xt(rc);
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          t[4*c+rr] = sbox[s[4*((c+rr)%4)+rr]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [31:0] lfsr32(input logic [31:0] x);
    return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
  endfunction

  // Core samples its inputs each edge; result emerges LATENCY edges later.
  logic [WIDTH-1:0] core_pipe [LATENCY];
  always @(posedge clk) begin
    core_pipe[0] <= aes_enc(core_state, core_key);
    for (int i = 1; i < LATENCY; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign core_out = core_pipe[LATENCY-1];

  // ---------------- tests ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 2'b00; en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b1; req_valid = 2'b11;
    req_state = {128'h1, 128'h2}; req_key = {128'h3, 128'h4};
    #1;
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready: got %b want 00", req_ready); end
    @(negedge clk);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (out_id !== 1'b0) begin bad++; $display("FAIL reset_out_id: got %b want 0", out_id); end
    total++; if (inflight !== 5'd0) begin bad++; $display("FAIL reset_inflight: got %0d want 0", inflight); end
    total++; if (done_count !== 32'd0) begin bad++; $display("FAIL reset_done_count: got %0d want 0", done_count); end
    total++; if (core_state !== '0 || core_key !== '0) begin bad++; $display("FAIL reset_core_regs: got %h/%h want 0", core_state, core_key); end
    rst = 1'b0; req_valid = 2'b00;
  endtask

  task automatic test_single();
    logic [127:0] pt, k, ct;
    int first_n, hits;
    do_reset();
    pt = 128'h00112233445566778899aabbccddeeff;
    k  = 128'h000102030405060708090a0b0c0d0e0f;
    ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    @(negedge clk);
    req_valid = 2'b01; req_state = {128'h0, pt}; req_key = {128'h0, k};
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL single_grant: got %b want 01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    total++; if (core_state !== pt || core_key !== k) begin bad++; $display("FAIL single_core_regs: got %h/%h", core_state, core_key); end
    total++; if (inflight !== 5'd1) begin bad++; $display("FAIL single_inflight: got %0d want 1", inflight); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL idle_data_zero: got %h want 0", out_data); end
    first_n = 0; hits = 0;
    for (int n = 2; n <= 40; n++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        hits++;
        if (first_n == 0) begin
          first_n = n;
          total++; if (out_id !== 1'b0) begin bad++; $display("FAIL single_id: got %b want 0", out_id); end
          total++; if (out_data !== ct) begin bad++; $display("FAIL single_data: got %h want %h", out_data, ct); end
        end
      end
    end
    total++; if (first_n != LATENCY + 1) begin bad++; $display("FAIL single_latency: got %0d want %0d", first_n, LATENCY + 1); end
    total++; if (hits != 1) begin bad++; $display("FAIL single_hits: got %0d want 1", hits); end
    total++; if (done_count !== 32'd1) begin bad++; $display("FAIL single_done_count: got %0d want 1", done_count); end
    total++; if (inflight !== 5'd0) begin bad++; $display("FAIL single_drain: got %0d want 0", inflight); end
  endtask

  task automatic test_contention();
    logic [127:0] s0, k0, s1, k1, e0, e1;
    logic [1:0]   exp_rdy;
    logic [4:0]   peak;
    logic         want_id;
    int           ret0, ret1, nret;
    do_reset();
    s0 = 128'h0123456789abcdef0011223344556677; k0 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    s1 = 128'h3243f6a8885a308d313198a2e0370734; k1 = 128'hffeeddccbbaa99887766554433221100;
    e0 = aes_enc(s0, k0);
    e1 = aes_enc(s1, k1);
    peak = 5'd0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (inflight > peak) peak = inflight;
      req_valid = 2'b11; req_state = {s1, s0}; req_key = {k1, k0};
      #1;
      exp_rdy = c[0] ? 2'b10 : 2'b01;
      total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL contention_grant c=%0d: got %b want %b", c, req_ready, exp_rdy); end
    end
    @(negedge clk);
    req_valid = 2'b00;
    nret = 0; ret0 = 0; ret1 = 0;
    for (int n = 0; n < 40; n++) begin
      if (inflight > peak) peak = inflight;
      if (out_valid === 1'b1) begin
        want_id = nret[0];
        total++; if (out_id !== want_id) begin bad++; $display("FAIL contention_order #%0d: got %b want %b", nret, out_id, want_id); end
        total++; if (out_data !== (want_id ? e1 : e0)) begin bad++; $display("FAIL contention_data #%0d: got %h want %h", nret, out_data, want_id ? e1 : e0); end
        if (out_id) ret1++; else ret0++;
        nret++;
      end
      @(negedge clk);
    end
    total++; if (peak !== 5'd10) begin bad++; $display("FAIL contention_peak: got %0d want 10", peak); end
    total++; if (ret0 != 5 || ret1 != 5) begin bad++; $display("FAIL contention_split: got %0d/%0d want 5/5", ret0, ret1); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] st [30];
    logic [127:0] ky [30];
    logic [127:0] ex [30];
    logic [31:0]  la, lb;
    logic [4:0]   peak;
    int           idx, first_n, last_n;
    la = 32'hDEADBEEF; lb = 32'hCAFEFEED;
    for (int j = 0; j < 30; j++) begin
      for (int w = 0; w < 4; w++) begin
        la = lfsr32(la); st[j][32*w +: 32] = la;
        lb = lfsr32(lb); ky[j][32*w +: 32] = lb;
      end
      ex[j] = aes_enc(st[j], ky[j]);
    end
    do_reset();
    idx = 0; first_n = -1; last_n = -1; peak = 5'd0;
    for (int n = 0; n < 70; n++) begin
      @(negedge clk);
      if (inflight > peak) peak = inflight;
      if (out_valid === 1'b1) begin
        if (first_n < 0) first_n = n;
        last_n = n;
        total++;
        if (idx >= 30 || out_id !== 1'b1 || out_data !== ex[idx]) begin
          bad++; $display("FAIL b2b_result #%0d: got id=%b data=%h", idx, out_id, out_data);
        end
        idx++;
      end
      if (n < 30) begin
        req_valid = 2'b10; req_state = {st[n], 128'h0}; req_key = {ky[n], 128'h0};
        #1;
        total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL b2b_grant n=%0d: got %b want 10", n, req_ready); end
      end else begin
        req_valid = 2'b00;
      end
    end
    total++; if (peak !== 5'd21) begin bad++; $display("FAIL b2b_peak: got %0d want 21", peak); end
    total++; if (idx != 30) begin bad++; $display("FAIL b2b_count: got %0d want 30", idx); end
    total++; if (last_n - first_n + 1 != 30) begin bad++; $display("FAIL b2b_consecutive: got span %0d want 30", last_n - first_n + 1); end
  endtask

  task automatic test_en_drop();
    logic [1:0] exp_rdy;
    int         hits;
    do_reset();
    @(negedge clk);
    en = 1'b0; req_valid = 2'b10; req_state = {128'hA1, 128'hA0}; req_key = {128'hB1, 128'hB0};
    #1;
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL en_low_ready: got %b want 00", req_ready); end
    @(negedge clk);
    req_valid = 2'b00; en = 1'b1;
    hits = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        total++; if (out_id !== hits[0]) begin bad++; $display("FAIL en_drop_id #%0d: got %b want %b", hits, out_id, hits[0]); end
        hits++;
      end
      if (n < 3) begin
        en = 1'b1; req_valid = 2'b11;
        #1;
        exp_rdy = (n == 1) ? 2'b10 : 2'b01;
        total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL en_grant n=%0d: got %b want %b", n, req_ready, exp_rdy); end
      end else if (n < 15) begin
        en = 1'b0; req_valid = 2'b11;
        #1;
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL en_drop_ready n=%0d: got %b want 00", n, req_ready); end
      end else begin
        en = 1'b1; req_valid = 2'b00;
      end
    end
    total++; if (hits != 3) begin bad++; $display("FAIL en_drop_count: got %0d want 3", hits); end
  endtask

  task automatic test_reset_midflight();
    int hits;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      req_valid = 2'b11; req_state = {128'hC1, 128'hC0}; req_key = {128'hD1, 128'hD0};
    end
    @(negedge clk);
    req_valid = 2'b00;
    total++; if (inflight !== 5'd8) begin bad++; $display("FAIL mid_inflight: got %0d want 8", inflight); end
    rst = 1'b1; req_valid = 2'b11;
    #1;
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL mid_rst_ready: got %b want 00", req_ready); end
    @(negedge clk);
    rst = 1'b0; req_valid = 2'b00;
    total++; if (inflight !== 5'd0) begin bad++; $display("FAIL mid_inflight_clear: got %0d want 0", inflight); end
    total++; if (done_count !== 32'd0) begin bad++; $display("FAIL mid_done_clear: got %0d want 0", done_count); end
    hits = 0;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || out_data !== '0) hits++;
    end
    total++; if (hits != 0) begin bad++; $display("FAIL mid_ghost_results: got %0d want 0", hits); end
  endtask

  task automatic test_wrap();
    int hits;
    do_reset();
    @(negedge clk);
    force dut.done_count = 32'hFFFFFFFF;
    @(negedge clk);
    release dut.done_count;
    req_valid = 2'b01; req_state = {128'h0, 128'h55}; req_key = {128'h0, 128'h66};
    @(negedge clk);
    req_valid = 2'b00;
    hits = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (out_valid === 1'b1) hits++;
    end
    total++; if (hits != 1) begin bad++; $display("FAIL wrap_hits: got %0d want 1", hits); end
    total++; if (done_count !== 32'd0) begin bad++; $display("FAIL wrap_done_count: got %h want 00000000", done_count); end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_en_drop();
    test_reset_midflight();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
